mvm_frame_ctrl: RTL and testbench
=================================

Name: mvm_frame_ctrl

Overview:
- Frame controller between the UART receiver, the matrix-vector multiply (MVM) engine and the UART transmitter.
- Parses command-headed byte frames from RX. Captures the kernel matrix K (R×C) and vector x (C).
- Launches one MVM operation per frame, then serialises the R result words back to TX, row 0 first.
- Supports kernel reuse: an x-only frame runs against the previously loaded K.

Parameters:
- R, 2, kernel rows / output length
- C, 2, kernel columns / vector length
- W_K, 4, kernel element width (bits)
- W_X, 4, vector element width (bits)
- W_Y_OUT, 8, result element width; must equal BITS_PER_WORD
- BITS_PER_WORD, 8, UART byte width
- CMD_FULL, 8'hA5, header byte: K then x follow
- CMD_XONLY, 8'h5A, header byte: only x follows, stored K reused

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- s_rx_data  in  BITS_PER_WORD  received byte
- s_rx_valid  in  1  one-cycle strobe per byte; no backpressure
- mvm_s_data  out  R*C*W_K+C*W_X  packed {x,K} operand
- mvm_s_valid  out  1  operand valid
- mvm_s_ready  in  1  engine accepts operand
- mvm_m_data  in  R*W_Y_OUT  packed result y
- mvm_m_valid  in  1  result valid
- mvm_m_ready  out  1  controller accepts result
- m_tx_data  out  BITS_PER_WORD  byte to transmitter
- m_tx_valid  out  1  byte valid
- m_tx_ready  in  1  transmitter accepts byte
- busy  out  1  high in every state except IDLE
- k_loaded  out  1  a complete K has been captured since reset
- err_cmd  out  1  one-cycle pulse on an illegal header byte
- err_overrun  out  1  one-cycle pulse when an RX byte is dropped

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE; all outputs 0, including busy, k_loaded, valids and error pulses.
  - K and x registers cleared to 0.
  - Byte index counter = 0.
- Packing:
  - Byte value uses the low W_K (or W_X) bits; upper bits are ignored.
  - K(r,c) is at mvm_s_data[(r*C+c)*W_K +: W_K].
  - x(c) is at mvm_s_data[R*C*W_K + c*W_X +: W_X].
  - K bytes arrive row-major, then x bytes in index order.
  - y(r) is at mvm_m_data[r*W_Y_OUT +: W_Y_OUT].
- States:
  - IDLE, on s_rx_valid:
    - CMD_FULL → LOAD_K.
    - CMD_XONLY and k_loaded=1 → LOAD_X.
    - Any other byte, or CMD_XONLY with k_loaded=0 → err_cmd pulse, stay in IDLE.
  - LOAD_K: each strobe writes K[idx], idx++. After byte R*C-1: idx←0, k_loaded←1, → LOAD_X.
  - LOAD_X: each strobe writes x[idx]. After byte C-1: idx←0, → FIRE.
  - FIRE: mvm_s_valid=1 starting the cycle after the last x byte. Held stable until mvm_s_ready; the handshake moves to WAIT_Y.
  - WAIT_Y: mvm_m_ready=1. On mvm_m_valid, latch y into a shift register, row ← 0, → SEND.
  - SEND:
    - m_tx_data=y(row), m_tx_valid=1.
    - Each m_tx_valid&m_tx_ready handshake advances row.
    - The handshake on row R-1 → IDLE (the next cycle has busy=0).
    - Data and valid stay stable while m_tx_ready=0.
- Overrun: s_rx_valid in FIRE, WAIT_Y or SEND → byte dropped, err_overrun pulse, state unchanged.
- Partial frames: there is no timeout. A partial frame waits indefinitely; only rst aborts it.
- Reset mid-operation: returns to IDLE and clears k_loaded. Any pending engine or TX handshake is abandoned, with valids low the next cycle.
- K stability: a CMD_FULL frame overwrites K byte-by-byte. If it is aborted by rst, K is cleared.
- Simultaneous events: mvm_s_valid and mvm_m_ready are never high in the same cycle.

Decomposition:
- Shared package mvm_pkg holds:
  - the state enum;
  - CMD_FULL and CMD_XONLY;
  - widths K_BITS=R*C*W_K, X_BITS=C*W_X, Y_BITS=R*W_Y_OUT.
- One sub-module is natural: mvm_tx_serializer (load R words, emit one byte per ready handshake, done pulse). Byte capture stays in the top FSM.

Test Plan (R=C=2):
- Full frame, immediate handshakes:
  - RX A5,01,02,03,04,05,06 → mvm_s_data=24'h654321, mvm_s_valid the cycle after the 06 strobe, k_loaded=1.
  - Engine returns y={8'h27,8'h11} → TX 11 then 27, then busy=0.
- Kernel reuse:
  - After the frame above, RX 5A,07,08 → mvm_s_data=24'h874321.
  - Engine returns {8'h35,8'h17} → TX 17, 35.
- Illegal headers:
  - RX 5A after reset → err_cmd pulse, busy stays 0.
  - RX 3C → err_cmd pulse.
  - A following valid A5 frame proceeds normally.
- Backpressure:
  - Hold mvm_s_ready=0 for 10 cycles → mvm_s_data/valid stable throughout.
  - Hold m_tx_ready low 5 cycles on byte 0 → m_tx_data=11 held, exactly 2 bytes emitted.
- Overrun: RX byte FF during WAIT_Y → err_overrun pulse, y output unaffected.
- Reset mid-frame:
  - Assert rst after A5,01,02 → IDLE, k_loaded=0, mvm_s_data=0.
  - A fresh full frame then produces correct output.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and constants for the MVM frame controller and its TX serializer.
package mvm_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_K = 3'd1,
      LOAD_X = 3'd2,
      FIRE   = 3'd3,
      WAIT_Y = 3'd4,
      SEND   = 3'd5
   } state_t;

   // Frame header bytes
   localparam logic [7:0] CMD_FULL  = 8'hA5;
   localparam logic [7:0] CMD_XONLY = 8'h5A;

   // Default geometry
   localparam int R_DEF       = 2;
   localparam int C_DEF       = 2;
   localparam int W_K_DEF     = 4;
   localparam int W_X_DEF     = 4;
   localparam int W_Y_OUT_DEF = 8;

   localparam int K_BITS = R_DEF * C_DEF * W_K_DEF;
   localparam int X_BITS = C_DEF * W_X_DEF;
   localparam int Y_BITS = R_DEF * W_Y_OUT_DEF;

   // Counter width able to index 0..n-1 (at least one bit)
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mvm_tx_serializer.sv
// Loads WORDS result words at once and hands them to the UART TX one per
// valid/ready handshake, word 0 first. done pulses with the final handshake.
module mvm_tx_serializer
   import mvm_pkg::*;
#(
   parameter int WORDS = 2,
   parameter int W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [WORDS*W-1:0]   load_data,
   output logic [W-1:0]         tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 done
);

   localparam int ROW_W = idx_width(WORDS);

   logic [WORDS*W-1:0] sh_q;
   logic [ROW_W-1:0]   row_q;
   logic               active_q;
   logic               fire;
   logic               last_row;

   assign fire     = active_q & tx_ready;
   assign last_row = (row_q == ROW_W'(WORDS - 1));
   assign done     = fire & last_row;
   assign tx_data  = sh_q[W-1:0];
   assign tx_valid = active_q;

   // Shift register: current word always sits in the low W bits
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q     <= '0;
         row_q    <= '0;
         active_q <= 1'b0;
      end else if (load) begin
         sh_q     <= load_data;
         row_q    <= '0;
         active_q <= 1'b1;
      end else if (fire) begin
         sh_q <= sh_q >> W;
         if (last_row) begin
            row_q    <= '0;
            active_q <= 1'b0;
         end else begin
            row_q <= row_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mvm_frame_ctrl.sv
// Frame controller: parses RX command frames into K and x, launches one MVM
// per frame and streams the R result bytes back to TX. x-only frames reuse K.
module mvm_frame_ctrl
   import mvm_pkg::*;
#(
   parameter int R             = 2,
   parameter int C             = 2,
   parameter int W_K           = 4,
   parameter int W_X           = 4,
   parameter int W_Y_OUT       = 8,
   parameter int BITS_PER_WORD = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [BITS_PER_WORD-1:0]      s_rx_data,
   input  logic                          s_rx_valid,
   output logic [R*C*W_K+C*W_X-1:0]      mvm_s_data,
   output logic                          mvm_s_valid,
   input  logic                          mvm_s_ready,
   input  logic [R*W_Y_OUT-1:0]          mvm_m_data,
   input  logic                          mvm_m_valid,
   output logic                          mvm_m_ready,
   output logic [BITS_PER_WORD-1:0]      m_tx_data,
   output logic                          m_tx_valid,
   input  logic                          m_tx_ready,
   output logic                          busy,
   output logic                          k_loaded,
   output logic                          err_cmd,
   output logic                          err_overrun
);

   localparam int KB    = R * C * W_K;
   localparam int XB    = C * W_X;
   localparam int IDX_W = idx_width(R * C);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic [KB-1:0]      k_q;
   logic [XB-1:0]      x_q;
   logic               k_loaded_q;
   logic               err_cmd_q;
   logic               err_ovr_q;

   logic               last_k;
   logic               last_x;
   logic               hdr_err;
   logic               ovr;
   logic               ser_load;
   logic               ser_done;

   assign last_k = (idx_q == IDX_W'(R * C - 1));
   assign last_x = (idx_q == IDX_W'(C - 1));

   assign mvm_s_data  = {x_q, k_q};
   assign k_loaded    = k_loaded_q;
   assign err_cmd     = err_cmd_q;
   assign err_overrun = err_ovr_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and state-decoded outputs
   always_comb begin
      state_d     = state_q;
      busy        = 1'b1;
      mvm_s_valid = 1'b0;
      mvm_m_ready = 1'b0;
      ser_load    = 1'b0;
      hdr_err     = 1'b0;
      ovr         = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (s_rx_valid) begin
               if (s_rx_data == CMD_FULL)
                  state_d = LOAD_K;
               else if (s_rx_data == CMD_XONLY && k_loaded_q)
                  state_d = LOAD_X;
               else
                  hdr_err = 1'b1;
            end
         end
         LOAD_K: if (s_rx_valid && last_k) state_d = LOAD_X;
         LOAD_X: if (s_rx_valid && last_x) state_d = FIRE;
         FIRE: begin
            mvm_s_valid = 1'b1;
            ovr         = s_rx_valid;
            if (mvm_s_ready) state_d = WAIT_Y;
         end
         WAIT_Y: begin
            mvm_m_ready = 1'b1;
            ovr         = s_rx_valid;
            if (mvm_m_valid) begin
               ser_load = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            ovr = s_rx_valid;
            if (ser_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Byte capture into K / x, frame index, kernel-valid flag and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         k_q        <= '0;
         x_q        <= '0;
         k_loaded_q <= 1'b0;
         err_cmd_q  <= 1'b0;
         err_ovr_q  <= 1'b0;
      end else begin
         err_cmd_q <= hdr_err;
         err_ovr_q <= ovr;
         case (state_q)
            IDLE: if (s_rx_valid) idx_q <= '0;
            LOAD_K: if (s_rx_valid) begin
               k_q[int'(idx_q) * W_K +: W_K] <= s_rx_data[W_K-1:0];
               if (last_k) begin
                  idx_q      <= '0;
                  k_loaded_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            LOAD_X: if (s_rx_valid) begin
               x_q[int'(idx_q) * W_X +: W_X] <= s_rx_data[W_X-1:0];
               if (last_x) idx_q <= '0;
               else        idx_q <= idx_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   mvm_tx_serializer #(
      .WORDS (R),
      .W     (W_Y_OUT)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .load_data (mvm_m_data),
      .tx_data   (m_tx_data),
      .tx_valid  (m_tx_valid),
      .tx_ready  (m_tx_ready),
      .done      (ser_done)
   );

endmodule

// File: tb/tb_mvm_frame_ctrl.sv
// Directed bench for mvm_frame_ctrl with a frame-level model of K, x and the
// expected TX byte stream, plus hand-computed literal expectations.
module tb_mvm_frame_ctrl;

   localparam int R  = 2;
   localparam int C  = 2;
   localparam int WK = 4;
   localparam int WX = 4;
   localparam int WY = 8;
   localparam int BW = 8;
   localparam int KB = R * C * WK;
   localparam int XB = C * WX;
   localparam int YB = R * WY;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [BW-1:0]     s_rx_data = '0;
   logic              s_rx_valid = 1'b0;
   logic [KB+XB-1:0]  mvm_s_data;
   logic              mvm_s_valid;
   logic              mvm_s_ready = 1'b0;
   logic [YB-1:0]     mvm_m_data = '0;
   logic              mvm_m_valid = 1'b0;
   logic              mvm_m_ready;
   logic [BW-1:0]     m_tx_data;
   logic              m_tx_valid;
   logic              m_tx_ready = 1'b1;
   logic              busy;
   logic              k_loaded;
   logic              err_cmd;
   logic              err_overrun;

   always #5 clk = ~clk;

   mvm_frame_ctrl #(
      .R(R), .C(C), .W_K(WK), .W_X(WX), .W_Y_OUT(WY), .BITS_PER_WORD(BW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_rx_data(s_rx_data), .s_rx_valid(s_rx_valid),
      .mvm_s_data(mvm_s_data), .mvm_s_valid(mvm_s_valid), .mvm_s_ready(mvm_s_ready),
      .mvm_m_data(mvm_m_data), .mvm_m_valid(mvm_m_valid), .mvm_m_ready(mvm_m_ready),
      .m_tx_data(m_tx_data), .m_tx_valid(m_tx_valid), .m_tx_ready(m_tx_ready),
      .busy(busy), .k_loaded(k_loaded), .err_cmd(err_cmd), .err_overrun(err_overrun)
   );

   int nvec = 0;
   int nerr = 0;

   // Model: kernel / vector contents, kernel-valid flag, pending TX bytes
   int         mk[R*C];
   int         mx[C];
   bit         mkl;
   logic [7:0] exp_q[$];
   logic [7:0] tx_log[$];
   int         tx_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [KB+XB-1:0] model_op();
      logic [KB+XB-1:0] v;
      v = '0;
      for (int i = 0; i < R*C; i++) v[i*WK +: WK] = WK'(mk[i]);
      for (int c = 0; c < C; c++)   v[KB + c*WX +: WX] = WX'(mx[c]);
      return v;
   endfunction

   function automatic logic [YB-1:0] model_y();
      logic [YB-1:0] y;
      int s;
      y = '0;
      for (int r = 0; r < R; r++) begin
         s = 0;
         for (int c = 0; c < C; c++) s += mk[r*C+c] * mx[c];
         y[r*WY +: WY] = WY'(s % 256);
      end
      return y;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < R*C; i++) mk[i] = 0;
      for (int c = 0; c < C; c++)   mx[c] = 0;
      mkl = 1'b0;
   endtask

   // Compare process: live outputs against the model every cycle out of reset
   always @(negedge clk) begin
      if (!rst) begin
         logic [7:0] e;
         chk("k_loaded", k_loaded, mkl);
         chk("s_valid_m_ready_excl", mvm_s_valid & mvm_m_ready, 0);
         if (mvm_s_valid) chk("operand", mvm_s_data, model_op());
         if (m_tx_valid && m_tx_ready) begin
            tx_log.push_back(m_tx_data);
            tx_cnt++;
            chk("tx_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("tx_byte", m_tx_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      s_rx_data  = b;
      s_rx_valid = 1'b1;
      tick();
      s_rx_valid = 1'b0;
   endtask

   task automatic full_frame(input logic [31:0] kb, input logic [15:0] xb);
      send(8'hA5);
      for (int i = 0; i < R*C; i++) begin
         send(kb[i*8 +: 8]);
         mk[i] = int'(kb[i*8 +: 4]);
         if (i == R*C-1) mkl = 1'b1;
      end
      for (int c = 0; c < C; c++) begin
         send(xb[c*8 +: 8]);
         mx[c] = int'(xb[c*8 +: 4]);
      end
   endtask

   task automatic xonly_frame(input logic [15:0] xb);
      send(8'h5A);
      for (int c = 0; c < C; c++) begin
         send(xb[c*8 +: 8]);
         mx[c] = int'(xb[c*8 +: 4]);
      end
   endtask

   // Engine + TX sink: optional operand backpressure, overrun byte, TX stall
   task automatic run_op(input int hold_s, input bit ovr, input int hold_tx);
      logic [KB+XB-1:0] op0;
      logic [YB-1:0]    y;
      int               cnt0;
      cnt0 = tx_cnt;
      for (int i = 0; i < 50 && !mvm_s_valid; i++) tick();
      chk("s_valid_seen", mvm_s_valid, 1);
      op0 = mvm_s_data;
      for (int i = 0; i < hold_s; i++) begin
         tick();
         chk("s_valid_held", mvm_s_valid, 1);
         chk("s_data_held", mvm_s_data, op0);
      end
      mvm_s_ready = 1'b1;
      tick();
      mvm_s_ready = 1'b0;
      chk("s_valid_dropped", mvm_s_valid, 0);
      chk("m_ready_wait", mvm_m_ready, 1);
      if (ovr) begin
         send(8'hFF);
         chk("err_overrun_pulse", err_overrun, 1);
         chk("m_ready_after_ovr", mvm_m_ready, 1);
         tick();
         chk("err_overrun_clear", err_overrun, 0);
      end
      y = model_y();
      for (int r = 0; r < R; r++) exp_q.push_back(y[r*WY +: WY]);
      m_tx_ready  = (hold_tx == 0);
      mvm_m_data  = y;
      mvm_m_valid = 1'b1;
      tick();
      mvm_m_valid = 1'b0;
      mvm_m_data  = '0;
      chk("m_ready_dropped", mvm_m_ready, 0);
      for (int i = 0; i < hold_tx; i++) begin
         chk("tx_valid_held", m_tx_valid, 1);
         chk("tx_data_held", m_tx_data, 8'h11);
         tick();
      end
      m_tx_ready = 1'b1;
      for (int i = 0; i < 50 && busy; i++) tick();
      chk("busy_done", busy, 0);
      chk("tx_count", tx_cnt - cnt0, R);
      chk("tx_valid_idle", m_tx_valid, 0);
   endtask

   initial begin
      model_clear();
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_busy", busy, 0);
      chk("rst_k_loaded", k_loaded, 0);
      chk("rst_s_valid", mvm_s_valid, 0);
      chk("rst_m_ready", mvm_m_ready, 0);
      chk("rst_tx_valid", m_tx_valid, 0);
      chk("rst_s_data", mvm_s_data, 0);
      chk("rst_errs", {err_cmd, err_overrun}, 0);

      // Illegal headers: x-only without kernel, then unknown byte
      send(8'h5A);
      chk("err_cmd_xonly", err_cmd, 1);
      chk("busy_after_bad", busy, 0);
      tick();
      chk("err_cmd_clear", err_cmd, 0);
      send(8'h3C);
      chk("err_cmd_3c", err_cmd, 1);
      chk("busy_after_3c", busy, 0);

      // Full frame with immediate handshakes
      send(8'hA5);
      mk = '{0, 0, 0, 0};
      chk("busy_header", busy, 1);
      for (int i = 0; i < R*C; i++) begin
         send(8'(i + 1));
         mk[i] = i + 1;
      end
      mkl = 1'b1;
      send(8'h05); mx[0] = 5;
      chk("s_valid_not_early", mvm_s_valid, 0);
      send(8'h06); mx[1] = 6;
      chk("s_valid_after_last", mvm_s_valid, 1);
      chk("op_lit_1", mvm_s_data, 24'h654321);
      chk("k_loaded_1", k_loaded, 1);
      run_op(0, 1'b0, 0);
      chk("tx_lit_1a", tx_log[0], 8'h11);
      chk("tx_lit_1b", tx_log[1], 8'h27);

      // Kernel reuse, operand backpressure, overrun during WAIT_Y
      xonly_frame(16'h0807);
      chk("op_lit_2", mvm_s_data, 24'h874321);
      run_op(10, 1'b1, 0);
      chk("tx_lit_2a", tx_log[2], 8'h17);
      chk("tx_lit_2b", tx_log[3], 8'h35);

      // TX backpressure on byte 0
      full_frame(32'h04030201, 16'h0605);
      run_op(0, 1'b0, 5);
      chk("tx_lit_3a", tx_log[4], 8'h11);
      chk("tx_lit_3b", tx_log[5], 8'h27);

      // Reset mid-frame aborts and clears K
      send(8'hA5);
      send(8'h01);
      send(8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_clear();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_k_loaded", k_loaded, 0);
      chk("mid_rst_s_data", mvm_s_data, 0);
      send(8'h5A);
      chk("err_cmd_after_rst", err_cmd, 1);

      // Fresh frame; upper nibbles of data bytes must be ignored
      full_frame(32'hFCFBFAF9, 16'hFEFD);
      chk("op_lit_4", mvm_s_data, 24'hEDCBA9);
      run_op(0, 1'b0, 0);
      chk("tx_lit_4a", tx_log[6], 8'h01);
      chk("tx_lit_4b", tx_log[7], 8'h37);

      tick();
      chk("tx_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
